// File: rtl/fetch_prefetch_pkg.sv
//==== fetch_prefetch_pkg : shared widths and reset address for the fetch stage. Rev 1.0 ====
`default_nettype none

package fetch_prefetch_pkg;

  localparam int          C_ADDR_W     = 16;
  localparam int          C_INST_W     = 16;
  localparam int          C_DEPTH      = 4;
  localparam logic [15:0] C_RESET_ADDR = 16'h0000;

  // Width of a counter able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_prefetch_if.sv
//==== fetch_prefetch_if : IF-stage bus (memory read port + ID handshake + EX redirect). Rev 1.0 ====
`default_nettype none

interface fetch_prefetch_if
  import fetch_prefetch_pkg::*;
#(
  parameter int ADDR_W = C_ADDR_W,
  parameter int INST_W = C_INST_W
);

  logic              branch_i;
  logic [ADDR_W-1:0] baddr_i;
  logic              re_o;
  logic [ADDR_W-1:0] addr_o;
  logic [INST_W-1:0] inst_i;
  logic              v_o;
  logic              stall_i;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] origaddr_o;

  modport master (
    input  branch_i, baddr_i, inst_i, stall_i,
    output re_o, addr_o, v_o, inst_o, origaddr_o
  );

  modport slave (
    output branch_i, baddr_i, inst_i, stall_i,
    input  re_o, addr_o, v_o, inst_o, origaddr_o
  );

endinterface

`default_nettype wire

// File: rtl/fetch_prefetch_fifo.sv
//==== fetch_fifo : DEPTH-entry circular buffer with push/pop/clear and head output. Rev 1.0 ====
`default_nettype none

module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clear,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [W-1:0]           i_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [W-1:0]           o_head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + PW'(1);
      if (i_pop)  r_rd <= r_rd + PW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !i_clear && i_push) r_mem[r_wr] <= i_data;
  end

  assign o_count = r_count;
  // Empty queue presents zeros so stale entries never leak after a flush.
  assign o_head  = (r_count != '0) ? r_mem[r_rd] : '0;

endmodule

`default_nettype wire

// File: rtl/fetch_prefetch.sv
//==== fetch_prefetch : IF stage, pc + in-flight/kill tracking + prefetch queue; option FETCH_BYPASS_EN. Rev 1.0 ====
`default_nettype none

module fetch_prefetch
  import fetch_prefetch_pkg::*;
#(
  parameter int                ADDR_W     = C_ADDR_W,
  parameter int                INST_W     = C_INST_W,
  parameter int                DEPTH      = C_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(C_RESET_ADDR)
) (
  input  logic              clk,
  input  logic              rst,
  fetch_prefetch_if.master  bus
);

  localparam int CW = cnt_w(DEPTH);
  localparam int EW = INST_W + ADDR_W;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_infl_addr;
  logic              r_inflight;
  logic              r_kill;

  logic [CW-1:0]     w_count;
  logic [EW-1:0]     w_head;
  logic              w_q_valid;
  logic              w_resp;
  logic              w_byp;
  logic              w_v;
  logic              w_take;
  logic              w_pop;
  logic              w_push;
  logic [CW-1:0]     w_occ;
  logic              w_issue;

  assign w_q_valid = (w_count != '0);
  // Branch wins over a response arriving in the same cycle.
  assign w_resp    = r_inflight & ~r_kill & ~bus.branch_i;

`ifdef FETCH_BYPASS_EN
  assign w_byp = w_resp & ~w_q_valid;
`else
  assign w_byp = 1'b0;
`endif

  assign w_v    = w_q_valid | w_byp;
  assign w_take = w_v & ~bus.stall_i & ~bus.branch_i;
  assign w_pop  = w_take & w_q_valid;
  assign w_push = w_resp & ~(w_byp & ~bus.stall_i);

  assign w_occ   = w_count + CW'(r_inflight) - CW'(w_take);
  assign w_issue = rst & ~bus.branch_i & (w_occ < CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc        <= RESET_ADDR;
      r_infl_addr <= '0;
      r_inflight  <= 1'b0;
      r_kill      <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_infl_addr <= r_pc;
        r_pc        <= r_pc + ADDR_W'(1);
      end
      if (bus.branch_i) begin
        r_pc   <= bus.baddr_i;
        r_kill <= r_inflight;
      end else if (w_issue) begin
        r_kill <= 1'b0;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (bus.branch_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({bus.inst_i, r_infl_addr}),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign bus.re_o       = w_issue;
  assign bus.addr_o     = r_pc;
  assign bus.v_o        = w_v;
  assign bus.inst_o     = w_byp ? bus.inst_i  : w_head[EW-1:ADDR_W];
  assign bus.origaddr_o = w_byp ? r_infl_addr : w_head[ADDR_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_fetch_prefetch.sv
//==== tb_fetch_prefetch : directed bench with a queue-level reference model for fetch_prefetch. Rev 1.0 ====
`default_nettype none

module tb_fetch_prefetch;
  import fetch_prefetch_pkg::*;

  localparam int          AW    = 16;
  localparam int          IW    = 16;
  localparam int          DEPTH = 4;
  localparam logic [15:0] RA    = 16'h0000;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  fetch_prefetch_if #(.ADDR_W(AW), .INST_W(IW)) bus ();

  fetch_prefetch #(
    .ADDR_W     (AW),
    .INST_W     (IW),
    .DEPTH      (DEPTH),
    .RESET_ADDR (RA)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] word(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  // One-cycle-latency instruction memory.
  always @(posedge clk) bus.inst_i <= bus.re_o ? word(bus.addr_o) : 16'hDEAD;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of fetched addresses, one outstanding read, pc.
  logic [15:0] mq [$];
  logic [15:0] got [$];
  bit          m_infl = 1'b0;
  logic [15:0] m_infl_addr = 16'h0;
  logic [15:0] m_pc = RA;
  bit          m_was_rst = 1'b1;
  bit          m_byp, m_ev, m_pop, m_re;
  logic [15:0] m_ha;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (m_was_rst) begin
          chk("reset v_o", bus.v_o, 1'b0);
          chk("reset re_o", bus.re_o, 1'b0);
          chk("reset addr_o", bus.addr_o, RA);
          chk("reset inst_o", bus.inst_o, 16'h0);
          chk("reset origaddr_o", bus.origaddr_o, 16'h0);
        end
        mq.delete();
        m_infl    = 1'b0;
        m_pc      = RA;
        m_was_rst = 1'b1;
      end else begin
        m_byp = BYP && m_infl && (mq.size() == 0) && !bus.branch_i;
        m_ev  = (mq.size() != 0) || m_byp;
        m_ha  = m_byp ? m_infl_addr : ((mq.size() != 0) ? mq[0] : 16'h0);
        m_pop = m_ev && !bus.stall_i && !bus.branch_i;
        m_re  = !bus.branch_i && ((mq.size() + int'(m_infl) - (m_pop ? 1 : 0)) < DEPTH);
        chk("v_o", bus.v_o, m_ev);
        chk("re_o", bus.re_o, m_re);
        if (m_re) chk("addr_o", bus.addr_o, m_pc);
        if (m_ev) begin
          chk("origaddr_o", bus.origaddr_o, m_ha);
          chk("inst_o", bus.inst_o, word(m_ha));
        end
        if (bus.v_o && !bus.stall_i && !bus.branch_i) got.push_back(bus.origaddr_o);
        if (bus.branch_i) begin
          mq.delete();
          m_infl = 1'b0;
          m_pc   = bus.baddr_i;
        end else begin
          if (m_pop && !m_byp) void'(mq.pop_front());
          if (m_infl && !(m_byp && m_pop)) mq.push_back(m_infl_addr);
          m_infl = m_re;
          if (m_re) begin
            m_infl_addr = m_pc;
            m_pc        = m_pc + 16'h1;
          end
        end
        m_was_rst = 1'b0;
      end
    end
  end

  task automatic step(input bit r, input bit s, input bit b, input logic [15:0] ba);
    @(negedge clk);
    rst         = r;
    bus.stall_i  = s;
    bus.branch_i = b;
    bus.baddr_i  = ba;
  endtask

  int first_v;
  int mark;

  initial begin
    rst          = 1'b0;
    bus.stall_i  = 1'b0;
    bus.branch_i = 1'b0;
    bus.baddr_i  = 16'h0;
    step(0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);

    // Free run, stall window from cycle 3 to 12, then release.
    first_v = -1;
    for (int c = 0; c < 25; c++) begin
      step(1, (c >= 3 && c < 13), 0, 16'h0);
      #3;
      if (c == 0) begin
        chk("first re_o", bus.re_o, 1'b1);
        chk("first addr_o", bus.addr_o, RA);
      end
      if (first_v < 0 && bus.v_o) first_v = c;
      if (c == 12) chk("re_o held while full", bus.re_o, 1'b0);
    end
    chk("first v_o cycle", first_v, BYP ? 1 : 2);
    chk("stream length", (got.size() >= 10), 1'b1);
    for (int i = 0; i < got.size(); i++) chk("stream order", got[i], i);

    // Fill the queue, free one slot so a read is in flight, then branch.
    for (int i = 0; i < 8; i++) step(1, 1, 0, 16'h0);
    step(1, 0, 0, 16'h0);
    step(1, 1, 1, 16'h0100);
    mark = got.size();
    step(1, 0, 0, 16'h0);
    #3;
    chk("v_o after flush", bus.v_o, 1'b0);
    chk("re_o after flush", bus.re_o, 1'b1);
    chk("addr_o after flush", bus.addr_o, 16'h0100);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 16'h0);
    chk("flush first", got[mark], 16'h0100);
    chk("flush second", got[mark+1], 16'h0101);

    // Back-to-back branches: only the later target reaches ID.
    step(1, 0, 1, 16'h0200);
    step(1, 0, 1, 16'h0300);
    mark = got.size();
    for (int i = 0; i < 6; i++) step(1, 0, 0, 16'h0);
    chk("double branch first", got[mark], 16'h0300);
    chk("double branch second", got[mark+1], 16'h0301);

    // Address wrap.
    step(1, 0, 1, 16'hFFFE);
    mark = got.size();
    for (int i = 0; i < 8; i++) step(1, 0, 0, 16'h0);
    chk("wrap 0", got[mark],   16'hFFFE);
    chk("wrap 1", got[mark+1], 16'hFFFF);
    chk("wrap 2", got[mark+2], 16'h0000);
    chk("wrap 3", got[mark+3], 16'h0001);

    // Mid-stream reset with a read in flight.
    step(1, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    #3;
    chk("midreset v_o", bus.v_o, 1'b0);
    chk("midreset re_o", bus.re_o, 1'b0);
    chk("midreset addr_o", bus.addr_o, RA);
    mark = got.size();
    step(1, 0, 0, 16'h0);
    #3;
    chk("restart re_o", bus.re_o, 1'b1);
    chk("restart addr_o", bus.addr_o, RA);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 16'h0);
    chk("restart first", got[mark], 16'h0000);
    chk("restart second", got[mark+1], 16'h0001);

    step(1, 0, 0, 16'h0);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
